inst_sram_responder: RTL and testbench

- Responder end of the simple SRAM-style instruction interface (en, wen, addr, wdata, rdata) driven by the IF stage.
- Provides a word-organised, byte-writable on-chip memory with one-cycle read latency.
- Translates kseg0/kseg1 virtual fetch addresses to physical addresses and flags accesses outside the mapped window.
- Keeps access counters for bring-up and performance checks.

---
 rtl/inst_sram_responder_if.sv | 11 +
 rtl/inst_sram_responder.sv | 77 +++++++
 tb/tb_inst_sram_responder.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_sram_responder_if.sv
// Simple SRAM-style instruction bus between the IF stage (master) and the memory responder (slave).
interface inst_sram_responder_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, output wen, output addr, output wdata, input rdata);
  modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/inst_sram_responder.sv
// Word-organised, byte-writable instruction memory with one-cycle read latency,
// kseg0/kseg1 address folding, a sticky out-of-range flag and saturating access counters.
module inst_sram_responder #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [31:0] BASE_PADDR = 32'h1fc00000
) (
  input  logic                        clk,
  input  logic                        reset,
  inst_sram_responder_if.slave        bus,
  output logic                        err,
  input  logic                        clr_cnt,
  output logic [31:0]                 rd_cnt,
  output logic [31:0]                 wr_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  // One extra bit so the window size does not wrap for the largest memories.
  localparam logic [32:0] SPAN  = 33'd4 << ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           paddr;
  logic [31:0]           off;
  logic                  in_range;
  logic                  is_wr;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           rdata_q;

  // kseg0 and kseg1 both fold onto the low 512 MB of physical space.
  assign paddr    = bus.addr & 32'h1fff_ffff;
  assign off      = paddr - BASE_PADDR;
  assign in_range = (paddr >= BASE_PADDR) && ({1'b0, off} < SPAN);
  assign idx      = off[ADDR_WIDTH+1:2];
  assign is_wr    = |bus.wen;

  assign bus.rdata = rdata_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hffff_ffff) ? v : v + 32'd1;
  endfunction

  // Memory array has no reset so it maps onto a plain SRAM macro.
  always_ff @(posedge clk) begin
    if (!reset && bus.en && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wen[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 32'h0;
      err     <= 1'b0;
      rd_cnt  <= 32'h0;
      wr_cnt  <= 32'h0;
    end else begin
      // Read-first: a write also returns the word as it was before this edge.
      if (bus.en) begin
        if (in_range) begin
          rdata_q <= mem[idx];
        end else begin
          rdata_q <= 32'h0;
          err     <= 1'b1;
        end
      end

      if (clr_cnt) begin
        rd_cnt <= 32'h0;
        wr_cnt <= 32'h0;
      end else if (bus.en) begin
        if (is_wr) wr_cnt <= sat_inc(wr_cnt);
        else       rd_cnt <= sat_inc(rd_cnt);
      end
    end
  end

endmodule

// File: tb/tb_inst_sram_responder.sv
// Scoreboard bench for inst_sram_responder: expected rdata is queued when an access is driven
// and popped one cycle later when the responder's output is due.
module tb_inst_sram_responder;

  localparam int unsigned AW   = 16;
  localparam logic [31:0] BASE = 32'h1fc00000;

  typedef struct {
    logic        chk;
    logic [31:0] val;
  } sb_t;

  logic        clk;
  logic        reset;
  logic        clr_cnt;
  logic        err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  inst_sram_responder_if bus ();

  inst_sram_responder #(.ADDR_WIDTH(AW), .BASE_PADDR(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .err     (err),
    .clr_cnt (clr_cnt),
    .rd_cnt  (rd_cnt),
    .wr_cnt  (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_err;
  sb_t         sb_q[$];
  logic [31:0] mem_m [int];
  logic        err_m;
  logic [31:0] rd_m;
  logic [31:0] wr_m;
  logic [31:0] rdata_m;
  sb_t         e;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Independent reference translation using 64-bit byte arithmetic.
  task automatic xlate(input logic [31:0] a, output logic inr, output int idx);
    longint unsigned p;
    p   = longint'(a & 32'h1fffffff);
    inr = (p >= longint'(BASE)) && (p < longint'(BASE) + (longint'(4) << AW));
    idx = inr ? int'((p - longint'(BASE)) >> 2) : 0;
  endtask

  task automatic drive(input logic en_i, input logic [3:0] wen_i, input logic [31:0] a,
                       input logic [31:0] wd, input logic clr_i);
    logic        inr;
    int          idx;
    sb_t         x;
    logic [31:0] w;
    bus.en    = en_i;
    bus.wen   = wen_i;
    bus.addr  = a;
    bus.wdata = wd;
    clr_cnt   = clr_i;
    if (en_i) begin
      xlate(a, inr, idx);
      if (inr) begin
        x.chk = mem_m.exists(idx);
        x.val = x.chk ? mem_m[idx] : 32'h0;
        if (wen_i != 4'h0 && (x.chk || wen_i == 4'hf)) begin
          w = x.val;
          for (int i = 0; i < 4; i++) if (wen_i[i]) w[8*i +: 8] = wd[8*i +: 8];
          mem_m[idx] = w;
        end
      end else begin
        x.chk = 1'b1;
        x.val = 32'h0;
        err_m = 1'b1;
      end
      rdata_m = x.val;
      sb_q.push_back(x);
    end
    if (clr_i) begin
      rd_m = 32'h0;
      wr_m = 32'h0;
    end else if (en_i) begin
      if (wen_i != 4'h0) wr_m = (wr_m == 32'hffffffff) ? wr_m : wr_m + 1;
      else               rd_m = (rd_m == 32'hffffffff) ? rd_m : rd_m + 1;
    end
  endtask

  task automatic idle();
    bus.en  = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic do_reset(input logic with_write, input logic [31:0] a, input logic [31:0] wd);
    reset     = 1'b1;
    clr_cnt   = 1'b0;
    bus.en    = with_write;
    bus.wen   = 4'hf;
    bus.addr  = a;
    bus.wdata = wd;
    tick();
    reset   = 1'b0;
    bus.en  = 1'b0;
    err_m   = 1'b0;
    rd_m    = 32'h0;
    wr_m    = 32'h0;
    rdata_m = 32'h0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    do_reset(1'b0, 32'h0, 32'h0);
    n_chk++;
    if (bus.rdata !== 32'h0 || err !== 1'b0 || rd_cnt !== 32'h0 || wr_cnt !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state rdata=%h err=%b rd=%0d wr=%0d exp 0/0/0/0", bus.rdata, err, rd_cnt, wr_cnt);
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 4'hf, 32'hbfc00000, 32'h3c1d8000, 1'b0);
    tick();
    e = sb_q.pop_front();
    drive(1'b1, 4'h0, 32'hbfc00000, 32'h0, 1'b0);
    tick();
    idle();
    e = sb_q.pop_front();
    n_chk++;
    if (bus.rdata !== e.val) begin
      n_err++;
      $display("FAIL basic_read rdata got %h exp %h", bus.rdata, e.val);
    end
    n_chk++;
    if (wr_cnt !== wr_m || rd_cnt !== rd_m || err !== err_m) begin
      n_err++;
      $display("FAIL basic_counts wr=%0d rd=%0d err=%b exp %0d %0d %b", wr_cnt, rd_cnt, err, wr_m, rd_m, err_m);
    end
  endtask

  task automatic test_byte_lanes();
    drive(1'b1, 4'hf, 32'hbfc00000, 32'h11223344, 1'b0);
    tick();
    e = sb_q.pop_front();
    n_chk++;
    if (bus.rdata !== e.val) begin
      n_err++;
      $display("FAIL lanes_prior rdata got %h exp %h", bus.rdata, e.val);
    end
    drive(1'b1, 4'b0101, 32'hbfc00000, 32'haabbccdd, 1'b0);
    tick();
    e = sb_q.pop_front();
    n_chk++;
    if (bus.rdata !== e.val) begin
      n_err++;
      $display("FAIL lanes_read_first rdata got %h exp %h", bus.rdata, e.val);
    end
    drive(1'b1, 4'h0, 32'hbfc00000, 32'hffffffff, 1'b0);
    tick();
    idle();
    e = sb_q.pop_front();
    n_chk++;
    if (bus.rdata !== e.val || e.val !== 32'h11bb33dd) begin
      n_err++;
      $display("FAIL lanes_merge rdata got %h exp %h", bus.rdata, 32'h11bb33dd);
    end
  endtask

  task automatic test_alias();
    logic [31:0] addrs [3];
    addrs[0] = 32'h9fc00010;
    addrs[1] = 32'hbfc00010;
    addrs[2] = 32'hbfc00013;
    drive(1'b1, 4'hf, addrs[0], 32'hdeadbeef, 1'b0);
    for (int i = 1; i < 3; i++) begin
      tick();
      e = sb_q.pop_front();
      if (e.chk) begin
        n_chk++;
        if (bus.rdata !== e.val) begin
          n_err++;
          $display("FAIL alias_%0d rdata got %h exp %h", i, bus.rdata, e.val);
        end
      end
      drive(1'b1, 4'h0, addrs[i], 32'h0, 1'b0);
    end
    tick();
    idle();
    e = sb_q.pop_front();
    n_chk++;
    if (bus.rdata !== 32'hdeadbeef || e.val !== 32'hdeadbeef) begin
      n_err++;
      $display("FAIL alias_unaligned rdata got %h exp %h", bus.rdata, 32'hdeadbeef);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      if (i < 6) drive(1'b1, 4'hf, 32'hbfc00100 + 32'(4 * i), $urandom, 1'b0);
      else       drive(1'b1, 4'h0, 32'h9fc00100 + 32'(4 * (11 - i)), $urandom, 1'b0);
      tick();
      e = sb_q.pop_front();
      if (e.chk) begin
        n_chk++;
        if (bus.rdata !== e.val) begin
          n_err++;
          $display("FAIL b2b_%0d rdata got %h exp %h", i, bus.rdata, e.val);
        end
      end
    end
    idle();
    n_chk++;
    if (rd_cnt !== rd_m || wr_cnt !== wr_m) begin
      n_err++;
      $display("FAIL b2b_counts rd=%0d wr=%0d exp %0d %0d", rd_cnt, wr_cnt, rd_m, wr_m);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 4'hf, 32'hbfc00020, 32'h12345678, 1'b0);
    tick();
    void'(sb_q.pop_front());
    drive(1'b1, 4'h0, 32'hbfc00020, 32'h0, 1'b0);
    tick();
    e = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'($urandom), $urandom, $urandom, 1'b0);
      tick();
      n_chk++;
      if (bus.rdata !== rdata_m || rdata_m !== 32'h12345678 || rd_cnt !== rd_m || wr_cnt !== wr_m) begin
        n_err++;
        $display("FAIL hold_%0d rdata got %h exp %h rd=%0d wr=%0d exp %0d %0d",
                 i, bus.rdata, 32'h12345678, rd_cnt, wr_cnt, rd_m, wr_m);
      end
    end
    idle();
  endtask

  task automatic test_out_of_range();
    logic [31:0] addrs [4];
    addrs[0] = 32'hbfc00000 + (32'd4 << AW);
    addrs[1] = 32'hbfbffffc;
    addrs[2] = 32'hbfc00000;
    addrs[3] = 32'hbfc00000 + (32'd4 << AW) - 32'd4;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 3) ? 4'hf : 4'h0, addrs[i], 32'h0badcafe, 1'b0);
      tick();
      e = sb_q.pop_front();
      n_chk++;
      if ((e.chk && bus.rdata !== e.val) || err !== err_m) begin
        n_err++;
        $display("FAIL oor_%0d rdata got %h exp %h err=%b exp %b", i, bus.rdata, e.val, err, err_m);
      end
    end
    drive(1'b1, 4'h0, addrs[3], 32'h0, 1'b0);
    tick();
    idle();
    e = sb_q.pop_front();
    n_chk++;
    if (bus.rdata !== 32'h0badcafe || e.val !== 32'h0badcafe) begin
      n_err++;
      $display("FAIL oor_last_word rdata got %h exp %h", bus.rdata, 32'h0badcafe);
    end
    do_reset(1'b0, 32'h0, 32'h0);
    n_chk++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL oor_err_reset err got %b exp 0", err);
    end
  endtask

  task automatic test_counter_edges();
    drive(1'b1, 4'h0, 32'hbfc00000, 32'h0, 1'b0);
    tick();
    void'(sb_q.pop_front());
    drive(1'b1, 4'h0, 32'hbfc00000, 32'h0, 1'b1);
    tick();
    idle();
    void'(sb_q.pop_front());
    n_chk++;
    if (rd_cnt !== rd_m || rd_m !== 32'h0) begin
      n_err++;
      $display("FAIL clr_wins rd_cnt got %0d exp 0", rd_cnt);
    end
    force dut.rd_cnt = 32'hffffffff;
    #1;
    release dut.rd_cnt;
    rd_m = 32'hffffffff;
    drive(1'b1, 4'h0, 32'hbfc00000, 32'h0, 1'b0);
    tick();
    idle();
    void'(sb_q.pop_front());
    n_chk++;
    if (rd_cnt !== rd_m) begin
      n_err++;
      $display("FAIL rd_saturate rd_cnt got %h exp %h", rd_cnt, rd_m);
    end
    drive(1'b1, 4'hf, 32'hbfc00040, 32'h55555555, 1'b0);
    tick();
    idle();
    void'(sb_q.pop_front());
    do_reset(1'b1, 32'hbfc00040, 32'hcafef00d);
    drive(1'b1, 4'h0, 32'hbfc00040, 32'h0, 1'b0);
    tick();
    idle();
    e = sb_q.pop_front();
    n_chk++;
    if (bus.rdata !== 32'h55555555 || e.val !== 32'h55555555) begin
      n_err++;
      $display("FAIL reset_write_ignored rdata got %h exp %h", bus.rdata, 32'h55555555);
    end
    n_chk++;
    if (rd_cnt !== 32'd1 || wr_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_no_count rd=%0d wr=%0d exp 1 0", rd_cnt, wr_cnt);
    end
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    reset     = 1'b1;
    clr_cnt   = 1'b0;
    bus.en    = 1'b0;
    bus.wen   = 4'h0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    err_m     = 1'b0;
    rd_m      = 32'h0;
    wr_m      = 32'h0;
    rdata_m   = 32'h0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_byte_lanes();
    test_alias();
    test_back_to_back();
    test_hold();
    test_out_of_range();
    test_counter_edges();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
